mii_tx_framer: RTL and testbench

Streaming Ethernet MII transmit framer that replaces the hard-coded transmit nibble table. It accepts a frame as a byte stream with a valid/ready/last handshake and prepends the preamble and SFD. It zero-pads short frames to the minimum length, appends a computed CRC-32 FCS, and enforces the inter-frame gap. It sits between a frame source (packet buffer or test generator) and the PHY MII transmit pins, clocked by the PHY TX clock.

---
 rtl/mii_pkg.sv | 16 +
 rtl/eth_crc32_nib.sv | 18 +
 rtl/mii_tx_framer.sv | 182 ++++++++++++++++++
 tb/tb_mii_tx_framer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_pkg.sv
// Shared state encoding and CRC-32 constants for the MII transmit path.
// No logic; imported by the framer and the CRC step.
package mii_pkg;

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG, ABORT} state_t;

  localparam logic [3:0]  MII_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  MII_SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC32_POLY_R     = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_crc32_nib.sv
// One reflected CRC-32 step over a nibble, LSB first; shared with the receive checker.
// Zero latency, purely combinational, no flow control.
module eth_crc32_nib
  import mii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nib,
  output logic [31:0] next_crc
);

  always_comb begin
    next_crc = crc ^ {28'd0, nib};
    for (int i = 0; i < 4; i++) begin
      next_crc = next_crc[0] ? ((next_crc >> 1) ^ CRC32_POLY_R) : (next_crc >> 1);
    end
  end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, byte-to-nibble, zero pad, CRC-32 FCS, inter-frame gap.
// Outputs registered (one cycle after state); o_ready only on SFD/high-nibble cycles and in ABORT.
module mii_tx_framer
  import mii_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int MIN_FRAME_BYTES  = 60,
  parameter int PAD_EN           = 1,
  parameter int FCS_EN           = 1,
  parameter int IFG_NIBBLES      = 24,
  parameter int CNT_W            = 32
) (
  input  logic             i_clk,
  input  logic             i_nreset,
  input  logic [7:0]       i_data,
  input  logic             i_valid,
  input  logic             i_last,
  output logic             o_ready,
  output logic             o_tx_en,
  output logic             o_tx_er,
  output logic [3:0]       o_tx_data,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_frame_count,
  output logic [CNT_W-1:0] o_underrun_count
);

  localparam logic [7:0]       PRE_N    = 8'(PREAMBLE_NIBBLES);
  localparam logic [7:0]       IFG_LAST = 8'(IFG_NIBBLES - 1);
  localparam logic [15:0]      MIN_B    = 16'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t      state;
  logic [7:0]  nib_cnt;
  logic [15:0] byte_cnt;
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [7:0]  dat_q;
  logic        last_q;
  logic        hi;
  logic        err_pend;
  logic [3:0]  crc_nib;
  logic [3:0]  fcs_nib;

  // A frame's final byte never asserts ready on its high nibble, so a held
  // i_valid cannot leak the next frame's first byte into this one.
  assign o_ready = ((state == PRE) && (nib_cnt == PRE_N))
                || ((state == DATA) && hi && !last_q)
                || (state == ABORT);
  assign o_busy  = (state != IDLE);
  assign crc_nib = (state == DATA) ? (hi ? dat_q[7:4] : dat_q[3:0]) : 4'h0;
  assign fcs_nib = 4'(~crc >> {nib_cnt[2:0], 2'b00});

  eth_crc32_nib u_crc (
    .crc      (crc),
    .nib      (crc_nib),
    .next_crc (crc_nxt)
  );

  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state            <= IDLE;
      nib_cnt          <= '0;
      byte_cnt         <= '0;
      crc              <= '0;
      dat_q            <= '0;
      last_q           <= 1'b0;
      hi               <= 1'b0;
      err_pend         <= 1'b0;
      o_tx_en          <= 1'b0;
      o_tx_er          <= 1'b0;
      o_tx_data        <= '0;
      o_frame_count    <= '0;
      o_underrun_count <= '0;
    end else begin
      o_tx_en   <= 1'b0;
      o_tx_er   <= 1'b0;
      o_tx_data <= '0;
      case (state)
        IDLE: if (i_valid) begin
          state     <= PRE;
          o_tx_en   <= 1'b1;
          o_tx_data <= MII_PREAMBLE_NIB;
          nib_cnt   <= 8'd1;
          crc       <= CRC32_INIT;
          byte_cnt  <= '0;
          hi        <= 1'b0;
          err_pend  <= 1'b0;
        end
        PRE: begin
          o_tx_en <= 1'b1;
          if (nib_cnt == PRE_N) begin
            o_tx_data <= MII_SFD_NIB;
            state     <= DATA;
            hi        <= 1'b0;
            if (i_valid) begin
              dat_q    <= i_data;
              last_q   <= i_last;
              byte_cnt <= 16'd1;
            end else begin
              err_pend <= 1'b1;
            end
          end else begin
            o_tx_data <= MII_PREAMBLE_NIB;
            nib_cnt   <= nib_cnt + 8'd1;
          end
        end
        DATA: begin
          o_tx_en <= 1'b1;
          if (err_pend) begin
            o_tx_er          <= 1'b1;
            err_pend         <= 1'b0;
            o_underrun_count <= o_underrun_count + CNT_ONE;
            state            <= ABORT;
          end else if (!hi) begin
            o_tx_data <= dat_q[3:0];
            crc       <= crc_nxt;
            hi        <= 1'b1;
          end else begin
            o_tx_data <= dat_q[7:4];
            crc       <= crc_nxt;
            hi        <= 1'b0;
            nib_cnt   <= '0;
            if (last_q) begin
              if ((PAD_EN != 0) && (byte_cnt < MIN_B)) begin
                state <= PAD;
              end else if (FCS_EN != 0) begin
                state <= FCS;
              end else begin
                state         <= IFG;
                o_frame_count <= o_frame_count + CNT_ONE;
              end
            end else if (i_valid) begin
              dat_q    <= i_data;
              last_q   <= i_last;
              byte_cnt <= sat_inc16(byte_cnt);
            end else begin
              err_pend <= 1'b1;
            end
          end
        end
        PAD: begin
          o_tx_en <= 1'b1;
          crc     <= crc_nxt;
          hi      <= !hi;
          if (hi) begin
            byte_cnt <= sat_inc16(byte_cnt);
            if (byte_cnt >= MIN_B - 16'd1) begin
              nib_cnt <= '0;
              if (FCS_EN != 0) begin
                state <= FCS;
              end else begin
                state         <= IFG;
                o_frame_count <= o_frame_count + CNT_ONE;
              end
            end
          end
        end
        FCS: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= fcs_nib;
          if (nib_cnt == 8'd7) begin
            state         <= IFG;
            nib_cnt       <= '0;
            o_frame_count <= o_frame_count + CNT_ONE;
          end else begin
            nib_cnt <= nib_cnt + 8'd1;
          end
        end
        IFG: begin
          if (nib_cnt == IFG_LAST) state <= IDLE;
          else                     nib_cnt <= nib_cnt + 8'd1;
        end
        ABORT: if (i_valid && i_last) begin
          state   <= IFG;
          nib_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Randomized bench for mii_tx_framer against a frame-level reference model.
// Instance u_np runs with padding disabled for the standard CRC check string.
module tb_mii_tx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  d0, d1;
  logic        v0, v1, l0, l1;
  logic        rdy0, rdy1, en0, en1, er0, er1, busy0, busy1;
  logic [3:0]  txd0, txd1;
  logic [31:0] fcnt0, fcnt1, ucnt0, ucnt1;

  mii_tx_framer u_dut (
    .i_clk(clk), .i_nreset(rst_n), .i_data(d0), .i_valid(v0), .i_last(l0),
    .o_ready(rdy0), .o_tx_en(en0), .o_tx_er(er0), .o_tx_data(txd0), .o_busy(busy0),
    .o_frame_count(fcnt0), .o_underrun_count(ucnt0)
  );

  mii_tx_framer #(.PAD_EN(0)) u_np (
    .i_clk(clk), .i_nreset(rst_n), .i_data(d1), .i_valid(v1), .i_last(l1),
    .o_ready(rdy1), .o_tx_en(en1), .o_tx_er(er1), .o_tx_data(txd1), .o_busy(busy1),
    .o_frame_count(fcnt1), .o_underrun_count(ucnt1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Line monitors, sampled on the falling edge; tests index from snapshots.
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  int runs0[$];
  int runs1[$];
  int gaps0[$];
  int run0 = 0, run1 = 0, lo0 = 0, er_seen0 = 0, rdylo0 = 0, bad_idle0 = 0;
  bit prev0 = 0, prev1 = 0, seen0 = 0;

  always @(negedge clk) begin
    if (en0) begin
      if (!prev0 && seen0) gaps0.push_back(lo0);
      lo0 = 0;
      run0++;
      seen0 = 1;
      q0.push_back(txd0);
    end else begin
      if (prev0) begin runs0.push_back(run0); run0 = 0; end
      lo0++;
      if (txd0 != 4'h0 || er0) bad_idle0++;
    end
    if (er0) er_seen0++;
    if (rdy0 && !en0) rdylo0++;
    prev0 = en0;
    if (en1) begin
      run1++;
      q1.push_back(txd1);
    end else if (prev1) begin
      runs1.push_back(run1);
      run1 = 0;
    end
    prev1 = en1;
  end

  logic [7:0] fb[$];
  logic [7:0] fa[$];
  logic [7:0] fbk[$];

  task automatic drive(input int inst, input logic v, input logic [7:0] d, input logic l);
    if (inst == 0) begin v0 = v; d0 = d; l0 = l; end
    else           begin v1 = v; d1 = d; l1 = l; end
  endtask

  task automatic send(input int inst, input int nbytes, input int stall_at,
                      input int stall_cyc, input bit hold);
    int i;
    int guard;
    bit took;
    i = 0;
    guard = 0;
    drive(inst, 1'b1, fb[0], nbytes == 1);
    while (i < nbytes && guard < 4000) begin
      @(negedge clk);
      took = (inst == 0) ? rdy0 : rdy1;
      @(posedge clk); #1;
      guard++;
      if (took) begin
        i++;
        if (i < nbytes) begin
          if (i == stall_at) begin
            drive(inst, 1'b0, 8'h00, 1'b0);
            repeat (stall_cyc) @(posedge clk);
            #1;
          end
          drive(inst, 1'b1, fb[i], i == nbytes - 1);
        end
      end
    end
    chk("send_all_bytes_taken", i, nbytes);
    if (!hold) drive(inst, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle(input int inst, input string tag);
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while (((inst == 0) ? busy0 : busy1) && g < 3000);
    chk(tag, (inst == 0) ? busy0 : busy1, 0);
  endtask

  function automatic logic [3:0] qnib(input int inst, input int idx);
    if (inst == 0) return (idx < q0.size()) ? q0[idx] : 4'hx;
    return (idx < q1.size()) ? q1[idx] : 4'hx;
  endfunction

  function automatic logic [31:0] get_fcs(input int inst, input int idx);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v[4*k +: 4] = qnib(inst, idx + k);
    return v;
  endfunction

  // Reference: pad the byte list, CRC it bit-serially, then expand to the nibble stream.
  task automatic cmp_frame(input string tag, input int inst, input int qs, input int ri,
                           input int nb, input bit pad, input bit fcs, input bit errnib,
                           output int elen);
    logic [7:0]  fr[$];
    logic [3:0]  ex[$];
    logic [31:0] c;
    int mism;
    int rl;
    fr = {};
    for (int i = 0; i < nb; i++) fr.push_back(fb[i]);
    if (pad) while (fr.size() < 60) fr.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fr[i]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ fr[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                 c = c >> 1;
      end
    end
    c = ~c;
    ex = {};
    repeat (15) ex.push_back(4'h5);
    ex.push_back(4'hD);
    foreach (fr[i]) begin ex.push_back(fr[i][3:0]); ex.push_back(fr[i][7:4]); end
    if (fcs) for (int k = 0; k < 8; k++) ex.push_back(c[4*k +: 4]);
    if (errnib) ex.push_back(4'h0);
    mism = 0;
    foreach (ex[i]) if (qnib(inst, qs + i) !== ex[i]) mism++;
    chk({tag, "_nibble_mismatches"}, mism, 0);
    if (inst == 0) rl = (runs0.size() > ri) ? runs0[ri] : -1;
    else           rl = (runs1.size() > ri) ? runs1[ri] : -1;
    chk({tag, "_tx_en_cycles"}, rl, ex.size());
    if (fcs) chk({tag, "_fcs"}, get_fcs(inst, qs + ex.size() - 8), c);
    elen = ex.size();
  endtask

  int exp_fc0 = 0;

  task automatic run_frame(input string tag, input int n);
    int qs;
    int ri;
    int elen;
    qs = q0.size();
    ri = runs0.size();
    send(0, n, -1, 0, 1'b0);
    wait_idle(0, {tag, "_idle"});
    cmp_frame(tag, 0, qs, ri, n, 1'b1, 1'b1, 1'b0, elen);
    exp_fc0++;
    chk({tag, "_frame_count"}, fcnt0, exp_fc0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int qs, ri, gi, rb, eb, elen, n, g;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", en0, 0);
    chk("rst_tx_er", er0, 0);
    chk("rst_tx_data", txd0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_frame_count", fcnt0, 0);
    chk("rst_underrun_count", ucnt0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Standard check string through the unpadded instance.
    fb = {};
    for (int i = 0; i < 9; i++) fb.push_back(8'h31 + 8'(i));
    qs = q1.size();
    ri = runs1.size();
    send(1, 9, -1, 0, 1'b0);
    wait_idle(1, "crcvec_idle");
    cmp_frame("crcvec", 1, qs, ri, 9, 1'b0, 1'b1, 1'b0, elen);
    chk("crcvec_golden_fcs", get_fcs(1, qs + 34), 32'hCBF43926);
    chk("crcvec_en_42", (runs1.size() > ri) ? runs1[ri] : -1, 42);
    chk("crcvec_frame_count", fcnt1, 1);

    // Minimum-size frame: broadcast dst, fixed src, IPv4 type, zero payload.
    fb = {};
    repeat (6) fb.push_back(8'hFF);
    fb.push_back(8'h00); fb.push_back(8'h0E); fb.push_back(8'hC4);
    fb.push_back(8'hC6); fb.push_back(8'h42); fb.push_back(8'hF2);
    fb.push_back(8'h08); fb.push_back(8'h00);
    while (fb.size() < 60) fb.push_back(8'h00);
    run_frame("minframe", 60);

    // Short frame padded out to 60 bytes.
    fb = {};
    for (int i = 0; i < 14; i++) fb.push_back(8'($urandom));
    run_frame("pad14", 14);

    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 90);
      fb = {};
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
      run_frame($sformatf("rand%0d_len%0d", t, n), n);
    end

    // Two 64-byte frames with i_valid held across the boundary.
    qs = q0.size();
    ri = runs0.size();
    gi = gaps0.size();
    rb = rdylo0;
    fb = {};
    for (int i = 0; i < 64; i++) fb.push_back(8'($urandom));
    send(0, 64, -1, 0, 1'b1);
    fa = fb;
    fb = {};
    for (int i = 0; i < 64; i++) fb.push_back(8'($urandom));
    fbk = fb;
    send(0, 64, -1, 0, 1'b0);
    wait_idle(0, "b2b_idle");
    fb = fa;
    cmp_frame("b2b_a", 0, qs, ri, 64, 1'b1, 1'b1, 1'b0, elen);
    fb = fbk;
    cmp_frame("b2b_b", 0, qs + elen, ri + 1, 64, 1'b1, 1'b1, 1'b0, elen);
    chk("b2b_gap", (gaps0.size() > gi + 1) ? gaps0[gi + 1] : -1, 24);
    chk("b2b_ready_while_idle", rdylo0 - rb, 0);
    exp_fc0 += 2;
    chk("b2b_frame_count", fcnt0, exp_fc0);

    // Underrun: source stalls after 20 bytes, then finishes the frame.
    qs = q0.size();
    ri = runs0.size();
    eb = er_seen0;
    fb = {};
    for (int i = 0; i < 40; i++) fb.push_back(8'($urandom));
    send(0, 40, 20, 6, 1'b0);
    wait_idle(0, "urun_idle");
    cmp_frame("urun", 0, qs, ri, 20, 1'b0, 1'b0, 1'b1, elen);
    chk("urun_tx_er_cycles", er_seen0 - eb, 1);
    chk("urun_underrun_count", ucnt0, 1);
    chk("urun_frame_count", fcnt0, exp_fc0);

    // Reset during the FCS nibbles.
    qs = q0.size();
    fb = {};
    for (int i = 0; i < 60; i++) fb.push_back(8'($urandom));
    send(0, 60, -1, 0, 1'b0);
    g = 0;
    while (q0.size() < qs + 139 && g < 2000) begin @(negedge clk); g++; end
    chk("rstmid_reached_fcs", q0.size() >= qs + 139, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_en", en0, 0);
    chk("rstmid_tx_er", er0, 0);
    chk("rstmid_frame_count", fcnt0, 0);
    chk("rstmid_underrun_count", ucnt0, 0);
    chk("rstmid_busy", busy0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_fc0 = 0;
    repeat (2) @(negedge clk);
    n = $urandom_range(20, 70);
    fb = {};
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    run_frame("after_reset", n);

    chk("idle_tx_data_and_er_clean", bad_idle0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
